car_collision: RTL
==================

# car_collision

Collision and lives controller sitting directly downstream of the per-lane car sprite movers. Compares every lane's car column (as driven by the car movers) against the player's grid cell each clock. On a hit it pulses a hit/respawn request, decrements the lives counter, and opens a grace window in which further hits are ignored. It holds GAME_OVER when lives reach zero, until restart.

## Interface
- NUM_LANES, 4: number of car lanes monitored.
- CAR_WIDTH, 2: car length in grid cells; it occupies columns car_x-CAR_WIDTH+1 .. car_x.
- START_LIVES, 3: lives loaded at reset and restart (1..7).
- GRACE_TICKS, 25000000: clocks of invulnerability after a hit (1 s at 25 MHz).

- i_Clk, in, 1: 25 MHz system clock, the only clock.
- i_Rst_n, in, 1: asynchronous, active-low reset.
- i_car_x, in, 5*NUM_LANES: packed car columns; lane k is bits [5k+4:5k], range 0..20.
- i_car_y, in, 4*NUM_LANES: packed lane rows; lane k is bits [4k+3:4k].
- i_player_x, in, 5: player column, 0..19.
- i_player_y, in, 4: player row.
- i_restart, in, 1: level-sampled restart request, honoured only in GAME_OVER.
- o_hit, out, 1: one-clock pulse per accepted collision.
- o_respawn, out, 1: one-clock pulse, coincident with o_hit when lives remain after the hit.
- o_lives, out, 3: remaining lives.
- o_grace, out, 1: high while in GRACE.
- o_game_over, out, 1: high in GAME_OVER.

## Operation
- Overlap for lane k: i_player_y == car_y[k] and car_x[k] - (CAR_WIDTH-1) <= i_player_x <= car_x[k].
- The subtraction is done in 6-bit signed-safe arithmetic. Car columns below CAR_WIDTH-1 clip the tail at column 0; there is no wrap to column 20.
- Column 20 is the off-screen re-entry slot. A car at x=20 only overlaps player columns 21-CAR_WIDTH..19.
- Stage 1 registers collide = OR of all lane overlaps. The FSM acts on the registered flag only.
- PLAY:
  - collide=1 with o_lives > 1: o_lives -= 1, o_hit=1, o_respawn=1, grace counter := GRACE_TICKS-1, go to GRACE.
  - collide=1 with o_lives == 1: o_lives := 0, o_hit=1, o_respawn=0, go to GAME_OVER.
- GRACE:
  - collide is ignored.
  - The counter decrements each clock; at 0, go to PLAY on the next clock.
- GAME_OVER:
  - collide is ignored; o_lives holds 0.
  - i_restart=1: o_lives := START_LIVES, go to PLAY.
- i_restart outside GAME_OVER has no effect.
- Several lanes overlapping in the same cycle count as one hit.
- Collision while o_lives == 0 is impossible by construction; PLAY is never entered with 0 lives.

## Timing
- Reset values (asynchronous on i_Rst_n low): state PLAY, o_lives=START_LIVES, o_hit=0, o_respawn=0, o_grace=0, o_game_over=0, grace counter 0, collide 0.
- Reset mid-GRACE or mid-GAME_OVER returns all of the above immediately. Release is synchronous to i_Clk.
- Latency: overlap present on inputs at edge N → collide=1 after edge N → o_hit/o_respawn high for the cycle after edge N+1. All of o_lives, o_grace and o_game_over update at edge N+1.
- All outputs are registered.
- GRACE lasts exactly GRACE_TICKS clocks: o_grace is high for GRACE_TICKS cycles, then PLAY.
- A still-present overlap at PLAY re-entry produces a new hit one clock later.
- GAME_OVER → PLAY takes one clock after i_restart is sampled high. A collision flagged on that same edge is ignored.
- o_hit never pulses on two consecutive clocks.

## Test plan
- Lane 0 at y=5, x=7, CAR_WIDTH=2; player at (6,5) → o_hit and o_respawn pulse 2 clocks later, o_lives 3→2, o_grace high for exactly 25000000 clocks (bench overrides GRACE_TICKS=8 and checks 8).
- Car x=1, player x=0, same row → hit. Car x=0, player x=1 → no hit. Car x=20, player x=19 → hit. Car x=20, player x=18 → no hit.
- Lanes 0 and 2 overlap the player in the same cycle → a single o_hit pulse and o_lives decrements by 1 only.
- Overlap held continuously, GRACE_TICKS=4, START_LIVES=3 → hits one clock after each grace exit. The third hit gives o_lives=0, o_game_over=1, o_respawn=0 and no further o_hit.
- In GAME_OVER, pulse i_restart → next clock o_lives=3, o_game_over=0. i_restart asserted in PLAY → no change.
- Assert i_Rst_n low mid-GRACE (lives=1) → outputs reach their reset values asynchronously. After release: o_lives=3, o_grace=0, PLAY.

Source files
------------

// File: rtl/car_collision.sv
// Collision and lives controller for the car lanes.
// Registers a lane-overlap flag, then runs the PLAY/GRACE/GAME_OVER FSM.
module car_collision #(
  parameter int NUM_LANES   = 4,
  parameter int CAR_WIDTH   = 2,
  parameter int START_LIVES = 3,
  parameter int GRACE_TICKS = 25000000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [5*NUM_LANES-1:0] i_car_x,
  input  logic [4*NUM_LANES-1:0] i_car_y,
  input  logic [4:0]             i_player_x,
  input  logic [3:0]             i_player_y,
  input  logic                   i_restart,
  output logic                   o_hit,
  output logic                   o_respawn,
  output logic [2:0]             o_lives,
  output logic                   o_grace,
  output logic                   o_game_over
);

  localparam int CNT_W =
    (GRACE_TICKS > 1) ? $clog2(GRACE_TICKS) : 1;
  localparam logic [CNT_W-1:0] GRACE_LOAD =
    CNT_W'(GRACE_TICKS - 1);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic signed [5:0] TAIL = 6'(CAR_WIDTH - 1);

  typedef enum logic [1:0] {
    PLAY,
    GRACE,
    GAME_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] grace_cnt;
  logic             collide;
  logic             overlap;

  // Tail may go negative near column 0; signed compare clips it.
  function automatic logic lane_hit(
    input logic [4:0] cx,
    input logic [3:0] cy,
    input logic [4:0] px,
    input logic [3:0] py
  );
    logic signed [5:0] head;
    logic signed [5:0] tail;
    logic signed [5:0] pos;
    head = $signed({1'b0, cx});
    tail = head - TAIL;
    pos  = $signed({1'b0, px});
    return (cy == py) && (tail <= pos) && (pos <= head);
  endfunction

  always_comb begin
    overlap = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_hit(i_car_x[5*k +: 5], i_car_y[4*k +: 4],
                   i_player_x, i_player_y))
        overlap = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= PLAY;
      grace_cnt   <= '0;
      collide     <= 1'b0;
      o_hit       <= 1'b0;
      o_respawn   <= 1'b0;
      o_lives     <= LIVES_INIT;
      o_grace     <= 1'b0;
      o_game_over <= 1'b0;
    end else begin
      collide   <= overlap;
      o_hit     <= 1'b0;
      o_respawn <= 1'b0;
      unique case (state)
        PLAY: begin
          if (collide) begin
            o_hit <= 1'b1;
            if (o_lives > 3'd1) begin
              o_lives   <= o_lives - 3'd1;
              o_respawn <= 1'b1;
              grace_cnt <= GRACE_LOAD;
              o_grace   <= 1'b1;
              state     <= GRACE;
            end else begin
              o_lives     <= 3'd0;
              o_game_over <= 1'b1;
              state       <= GAME_OVER;
            end
          end
        end
        GRACE: begin
          if (grace_cnt == '0) begin
            o_grace <= 1'b0;
            state   <= PLAY;
          end else begin
            grace_cnt <= grace_cnt - 1'b1;
          end
        end
        GAME_OVER: begin
          if (i_restart) begin
            o_lives     <= LIVES_INIT;
            o_game_over <= 1'b0;
            state       <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule
